// File: rtl/striping.sv
// striping: splits one word-per-cycle stream onto two half-rate lanes.
// Even words go to lane_0 and odd words to lane_1. Both lanes update
// together on the PH1 edge and then hold for two clk_2f cycles.
module striping #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] lane_0,
   output logic [WIDTH-1:0] lane_1,
   output logic             valid_0,
   output logic             valid_1,
   output logic             pair_strobe,
   output logic [CNT_W-1:0] word_count
);

   // IDLE: no pair is open. PH0: the even slot is sampled here.
   // PH1: the odd slot is sampled here and the lanes are updated.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PH0  = 2'd1,
      PH1  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] hold_0, hold_0_nxt;
   logic             hold_v0, hold_v0_nxt;
   logic [WIDTH-1:0] lane_0_nxt, lane_1_nxt;
   logic             valid_0_nxt, valid_1_nxt;
   logic             pair_strobe_nxt;
   logic [CNT_W-1:0] word_count_nxt;

   // Next-state and datapath decode for the pairing FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave a signal unassigned and infer a latch.
      state_nxt       = state;
      hold_0_nxt      = hold_0;
      hold_v0_nxt     = hold_v0;
      lane_0_nxt      = lane_0;
      lane_1_nxt      = lane_1;
      valid_0_nxt     = valid_0;
      valid_1_nxt     = valid_1;
      pair_strobe_nxt = 1'b0;
      word_count_nxt  = word_count;

      case (state)
         IDLE: begin
            // Any word arriving while idle opens a new pair as an even word.
            if (valid_in) begin
               hold_0_nxt  = data_in;
               hold_v0_nxt = 1'b1;
               state_nxt   = PH1;
            end
         end
         PH0: begin
            // The phase keeps toggling across single-word gaps; an empty
            // even slot is recorded as zero data with its flag cleared.
            hold_0_nxt  = valid_in ? data_in : '0;
            hold_v0_nxt = valid_in;
            state_nxt   = PH1;
         end
         PH1: begin
            lane_0_nxt      = hold_0;
            valid_0_nxt     = hold_v0;
            lane_1_nxt      = valid_in ? data_in : '0;
            valid_1_nxt     = valid_in;
            pair_strobe_nxt = 1'b1;
            word_count_nxt  = word_count + CNT_W'(hold_v0) + CNT_W'(valid_in);
            // A fully empty pair still flushes the lanes, then the stream
            // re-aligns so the next word lands on lane 0.
            if (!hold_v0 && !valid_in) state_nxt = IDLE;
            else                       state_nxt = PH0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_2f or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Holding register, lane outputs and counter.
   always_ff @(posedge clk_2f or negedge reset) begin
      if (!reset) begin
         hold_0      <= '0;
         hold_v0     <= 1'b0;
         lane_0      <= '0;
         lane_1      <= '0;
         valid_0     <= 1'b0;
         valid_1     <= 1'b0;
         pair_strobe <= 1'b0;
         word_count  <= '0;
      end else begin
         hold_0      <= hold_0_nxt;
         hold_v0     <= hold_v0_nxt;
         lane_0      <= lane_0_nxt;
         lane_1      <= lane_1_nxt;
         valid_0     <= valid_0_nxt;
         valid_1     <= valid_1_nxt;
         pair_strobe <= pair_strobe_nxt;
         word_count  <= word_count_nxt;
      end
   end

endmodule

// File: tb/tb_striping.sv
// tb_striping: scoreboard bench for striping. The stimulus side runs a
// slot-based reference model and queues the lane update it expects for
// each completed pair; a negedge monitor pops and compares on each strobe
// and checks the lanes stay stable between strobes.
module tb_striping;

   localparam int WIDTH = 32;
   localparam int CNT_W = 4;

   logic             clk_2f;
   logic             reset;
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic [WIDTH-1:0] lane_0;
   logic [WIDTH-1:0] lane_1;
   logic             valid_0;
   logic             valid_1;
   logic             pair_strobe;
   logic [CNT_W-1:0] word_count;

   striping #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_2f      (clk_2f),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .lane_0      (lane_0),
      .lane_1      (lane_1),
      .valid_0     (valid_0),
      .valid_1     (valid_1),
      .pair_strobe (pair_strobe),
      .word_count  (word_count)
   );

   initial clk_2f = 1'b0;
   always #5 clk_2f = ~clk_2f;

   typedef struct {
      logic [WIDTH-1:0] l0;
      logic             v0;
      logic [WIDTH-1:0] l1;
      logic             v1;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: a pair is two consecutive slots opened by the first
   // valid word seen while idle. Slot 0 is the even word, slot 1 the odd
   // word; an empty slot carries zero. Closing a pair with both slots
   // empty returns to idle. The count is the number of valid words
   // emitted, modulo 2**CNT_W.
   bit               m_open;
   int               m_slot;
   logic [WIDTH-1:0] m_even_d;
   logic             m_even_v;
   int               m_words;

   task automatic model_clear();
      m_open   = 0;
      m_slot   = 0;
      m_even_d = '0;
      m_even_v = 1'b0;
      m_words  = 0;
   endtask

   task automatic model_edge(input logic v, input logic [WIDTH-1:0] d);
      exp_t e;
      if (!m_open) begin
         if (v) begin
            m_open   = 1;
            m_even_d = d;
            m_even_v = 1'b1;
            m_slot   = 1;
         end
      end else if (m_slot == 0) begin
         m_even_d = v ? d : '0;
         m_even_v = v;
         m_slot   = 1;
      end else begin
         m_words = m_words + int'(m_even_v) + int'(v);
         e.l0  = m_even_d;
         e.v0  = m_even_v;
         e.l1  = v ? d : '0;
         e.v1  = v;
         e.cnt = CNT_W'(m_words % (1 << CNT_W));
         exp_q.push_back(e);
         if (!m_even_v && !v) m_open = 0;
         else                 m_slot = 0;
      end
   endtask

   // Drive one input word, let one edge pass, then step off the edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk_2f);
      if (reset) model_edge(v, d);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   // Asserted just after an edge, so it lands between two edges.
   task automatic pulse_reset();
      reset = 1'b0;
      model_clear();
      valid_in = 1'b0;
      data_in  = '0;
      repeat (2) @(posedge clk_2f);
      #1;
      reset = 1'b1;
   endtask

   // Monitor: compare against the scoreboard on each strobe, and check
   // the lanes hold their last values on all other cycles.
   exp_t last;
   always @(negedge clk_2f) begin
      if (!reset) begin
         check("rst_lane_0", 64'(lane_0), 64'd0);
         check("rst_lane_1", 64'(lane_1), 64'd0);
         check("rst_valids", {62'd0, valid_0, valid_1}, 64'd0);
         check("rst_strobe", 64'(pair_strobe), 64'd0);
         check("rst_count", 64'(word_count), 64'd0);
         last.l0 = '0; last.v0 = 1'b0; last.l1 = '0; last.v1 = 1'b0; last.cnt = '0;
      end else if (pair_strobe) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got 1 expected 0 at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("lane_0", 64'(lane_0), 64'(e.l0));
            check("valid_0", 64'(valid_0), 64'(e.v0));
            check("lane_1", 64'(lane_1), 64'(e.l1));
            check("valid_1", 64'(valid_1), 64'(e.v1));
            check("word_count", 64'(word_count), 64'(e.cnt));
            last = e;
         end
      end else begin
         check("hold_lanes", {lane_0, lane_1}, {last.l0, last.l1});
         check("hold_flags", {56'd0, valid_0, valid_1, 2'b00, word_count},
                             {56'd0, last.v0, last.v1, 2'b00, last.cnt});
      end
   end

   initial begin
      int rate;
      model_clear();
      // Reset with a busy input: everything must stay cleared.
      reset    = 1'b0;
      valid_in = 1'b1;
      data_in  = 32'hFFFF_FFFF;
      repeat (4) @(posedge clk_2f);
      #1;
      reset = 1'b1;
      idle(10);

      // Continuous stream.
      step(1'b1, 32'hA0); step(1'b1, 32'hA1); step(1'b1, 32'hA2); step(1'b1, 32'hA3);
      idle(4);

      // Single word then idle.
      step(1'b1, 32'h55);
      idle(5);

      // Gap mid-stream: B3 must land on lane 1.
      step(1'b1, 32'hB0); step(1'b1, 32'hB1); step(1'b0, '0); step(1'b1, 32'hB3);
      idle(4);

      // Reset mid-pair: C0 is discarded, C1 starts a fresh pair.
      step(1'b1, 32'hC0);
      pulse_reset();
      step(1'b1, 32'hC1);
      idle(4);

      // Counter wrap: 16 full pairs from a cleared counter.
      pulse_reset();
      for (int i = 0; i < 32; i++) step(1'b1, 32'hD000_0000 + i);
      idle(4);

      // Odd-count wrap: one word, then full pairs step 15 -> 1.
      pulse_reset();
      step(1'b1, 32'hE0);
      idle(4);
      for (int i = 0; i < 18; i++) step(1'b1, 32'hE100 + i);
      idle(4);

      // Randomized traffic with varying density and occasional resets.
      rate = 100;
      for (int i = 0; i < 2000; i++) begin
         if (i % 64 == 0) begin
            case ($urandom_range(0, 3))
               0:       rate = 100;
               1:       rate = 80;
               2:       rate = 50;
               default: rate = 10;
            endcase
         end
         if ($urandom_range(0, 499) == 0) pulse_reset();
         step($urandom_range(0, 99) < rate, $urandom);
      end
      idle(6);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/striping.md
# striping

Splitter that distributes a single WIDTH-bit word stream, arriving at one word per `clk_2f` cycle, alternately onto two lanes: even words on lane 0, odd words on lane 1. It is the transmit-side counterpart of the un-striping block and sits between the serial-rate byte path and the two parallel lanes. Each lane word is held stable for two `clk_2f` cycles, so half-rate logic can sample the lanes. Word order on the lanes matches the input order.

## Interface
- `WIDTH`, default 32, data word width.
- `CNT_W`, default 16, width of the emitted-word counter.

- `clk_2f` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data_in` input WIDTH: input word.
- `valid_in` input 1: `data_in` qualifier. Input is always accepted; there is no backpressure.
- `lane_0` output WIDTH: even-word lane, registered.
- `lane_1` output WIDTH: odd-word lane, registered.
- `valid_0` output 1: `lane_0` qualifier.
- `valid_1` output 1: `lane_1` qualifier.
- `pair_strobe` output 1: one-cycle pulse on every lane update.
- `word_count` output CNT_W: running total of valid words emitted on the lanes.

## Operation
- Internal state:
  - `hold_0`: WIDTH-bit holding register.
  - `hold_v0`: qualifier for `hold_0`.
  - FSM with states IDLE, PH0, PH1.
- Reset (`reset`=0, asynchronous):
  - state → IDLE.
  - `lane_0`, `lane_1`, `hold_0` → 0.
  - `valid_0`, `valid_1`, `hold_v0`, `pair_strobe` → 0.
  - `word_count` → 0.
- IDLE:
  - Lanes and valids hold their values.
  - If `valid_in`=1: `hold_0` ← `data_in`, `hold_v0` ← 1, go to PH1.
  - Otherwise stay in IDLE.
- PH0:
  - `hold_0` ← `valid_in` ? `data_in` : 0.
  - `hold_v0` ← `valid_in`.
  - Always go to PH1; the phase keeps toggling through single-word gaps.
- PH1, the lane update edge:
  - `lane_0` ← `hold_0`, `valid_0` ← `hold_v0`.
  - `lane_1` ← `valid_in` ? `data_in` : 0, `valid_1` ← `valid_in`.
  - `pair_strobe` ← 1.
  - `word_count` ← `word_count` + `hold_v0` + `valid_in`.
  - If `hold_v0`=0 and `valid_in`=0 (the pair is fully empty), the update still happens (lanes → 0, valids → 0, strobe pulses) and the FSM goes to IDLE. Otherwise it goes to PH0.
- `pair_strobe` is 0 on every edge not taken from PH1.
- An invalid lane always carries 0 data. High-Z is never driven.
- `word_count` is modulo 2^CNT_W and wraps silently. An increment of +2 from 2^CNT_W−1 yields 1.
- A half-filled pair is legal: lane 0 valid with lane 1 invalid, or the reverse. Each valid flag is independent.

## Timing
- Lane outputs change only on edges taken from PH1. Between updates they are stable for exactly 2 cycles in steady state.
- Latency:
  - A word sampled on an IDLE/PH0 edge k appears on `lane_0` after edge k+1.
  - A word sampled on a PH1 edge k appears on `lane_1` after edge k.
- `pair_strobe` and `word_count` update on the same edge as the lanes.
- Any 1 on `valid_in` while in IDLE is always treated as an even (lane 0) word. This re-aligns word order after idle periods.
- Reset asserted mid-pair discards `hold_0` with no lane update. After release, the first valid word goes to lane 0.

## Test plan
- **Reset values.** Hold `reset`=0 with `valid_in`=1 and `data_in`=32'hFFFFFFFF → all outputs 0, no strobe. Release, then keep `valid_in`=0 for 10 cycles → outputs remain 0 and `pair_strobe` never pulses.
- **Continuous stream.** Drive 32'hA0, 32'hA1, 32'hA2, 32'hA3 on consecutive edges 1-4 →
  - After edge 2: `lane_0`=A0, `lane_1`=A1, both valid, strobe=1, `word_count`=2.
  - After edge 3: lanes unchanged, strobe=0.
  - After edge 4: lanes A2/A3, `word_count`=4.
- **Single word then idle.** Drive 32'h55 on edge 1 only →
  - After edge 2: `lane_0`=55, `valid_0`=1, `lane_1`=0, `valid_1`=0, `word_count`=1.
  - After edge 4: lanes 0, valids 0, strobe pulse, FSM in IDLE.
- **Gap mid-stream.** Drive B0, B1, then a gap on edge 3, then B3 on edge 4 →
  - After edge 4: `lane_0`=0, `valid_0`=0, `lane_1`=B3, `valid_1`=1.
  - `word_count`=3, and the FSM does not enter IDLE.
- **Reset mid-pair.** Drive C0 on edge 1, assert `reset` between edges 1 and 2, release, then drive C1 →
  - C0 never appears on any lane.
  - C1 appears on `lane_0` two edges after release-sampling.
  - `word_count`=1.
- **Counter wrap.** With CNT_W=4, stream 16 full pairs (32 words) → `word_count` reads 0 after the 8th and 16th pairs and never exceeds 15.
